exec_unit_mp: RTL and testbench

Parametrised, multi-operation execution unit with output backpressure. Requests are buffered in an internal FIFO of configurable depth and dispatched in order to an adder/subtractor unit or a multiplier unit, each with configurable latency. Completed results are merged by a round-robin arbiter onto a valid/ready response port. It replaces the fixed-width, add/mul-only execution unit in the request/response path.

---
 rtl/exec_unit_mp.sv | 228 ++++++++++++++++++++++
 tb/tb_exec_unit_mp.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_mp.sv
// exec_unit_mp: in-order FIFO-fed execution unit with an add/sub slot and a multiply
// slot, whose results are merged onto a valid/ready response port by a round-robin arbiter.

module exec_unit_mp_slot #(
  parameter int LAT   = 1,
  parameter int ID_W  = 3,
  parameter int RES_W = 64
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [ID_W-1:0]  start_id,
  input  logic [RES_W-1:0] start_data,
  input  logic             start_err,
  input  logic             accept,
  output logic             idle,
  output logic             done,
  output logic [ID_W-1:0]  res_id,
  output logic [RES_W-1:0] res_data,
  output logic             res_err
);
  localparam int CNT_W = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [RES_W-1:0] data_q, data_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_DONE;
      S_DONE:  if (accept) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter loads LAT-1 on dispatch so the slot spends exactly LAT edges in RUN.
  always_comb begin
    cnt_d  = cnt_q;
    id_d   = id_q;
    data_d = data_q;
    err_d  = err_q;
    if (state_q == S_IDLE && start) begin
      cnt_d  = CNT_W'(LAT - 1);
      id_d   = start_id;
      data_d = start_data;
      err_d  = start_err;
    end else if (state_q == S_RUN && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    idle     = (state_q == S_IDLE);
    done     = (state_q == S_DONE);
    res_id   = id_q;
    res_data = data_q;
    res_err  = err_q;
  end
endmodule

module exec_unit_mp #(
  parameter int DATA_W     = 32,
  parameter int ID_W       = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int ADD_LAT    = 1,
  parameter int MUL_LAT    = 3
) (
  input  logic                              clk,
  input  logic                              rst_b,
  input  logic                              req_valid,
  input  logic [1:0]                        req_op,
  input  logic [ID_W-1:0]                   req_id,
  input  logic [DATA_W-1:0]                 req_data1,
  input  logic [DATA_W-1:0]                 req_data2,
  output logic                              fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [ID_W-1:0]                   rsp_id,
  output logic [2*DATA_W-1:0]               rsp_data,
  output logic                              rsp_err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RES_W = 2 * DATA_W;

  typedef struct packed {
    logic [1:0]        op;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] d2;
  } entry_t;

  entry_t           mem_q [FIFO_DEPTH];
  entry_t           wr_entry, head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, push, pop, head_mul;
  logic             add_start, mul_start;

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic [RES_W-1:0]  add_data, mul_data;
  logic              add_err;

  logic             add_idle, add_done, add_accept, add_res_err;
  logic             mul_idle, mul_done, mul_accept, mul_res_err;
  logic [ID_W-1:0]  add_res_id, mul_res_id;
  logic [RES_W-1:0] add_res_data, mul_res_data;

  logic ptr_mul_q, ptr_mul_d, lock_q, lock_d, lock_mul_q, lock_mul_d;
  logic gnt_mul, accept;

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ptr_mul_q  <= 1'b0;
      lock_q     <= 1'b0;
      lock_mul_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ptr_mul_q  <= ptr_mul_d;
      lock_q     <= lock_d;
      lock_mul_q <= lock_mul_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  always_comb begin
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    push      = req_valid && !full;
    wr_entry  = {req_op, req_id, req_data1, req_data2};
    head      = mem_q[rd_ptr_q];
    head_mul  = (head.op == 2'b10);
    pop       = (count_q != '0) && (head_mul ? mul_idle : add_idle);
    add_start = pop && !head_mul;
    mul_start = pop && head_mul;
    wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Illegal ops share the add slot and carry a zero result with the error flag.
  always_comb begin
    sum  = {1'b0, head.d1} + {1'b0, head.d2};
    diff = head.d1 - head.d2;
    case (head.op)
      2'b00:   add_data = {{(DATA_W-1){1'b0}}, sum};
      2'b01:   add_data = {{DATA_W{1'b0}}, diff};
      default: add_data = '0;
    endcase
    add_err  = (head.op == 2'b11);
    mul_data = {{DATA_W{1'b0}}, head.d1} * {{DATA_W{1'b0}}, head.d2};
  end

  exec_unit_mp_slot #(.LAT(ADD_LAT), .ID_W(ID_W), .RES_W(RES_W)) u_add (
    .clk(clk), .rst_b(rst_b),
    .start(add_start), .start_id(head.id), .start_data(add_data), .start_err(add_err),
    .accept(add_accept),
    .idle(add_idle), .done(add_done),
    .res_id(add_res_id), .res_data(add_res_data), .res_err(add_res_err)
  );

  exec_unit_mp_slot #(.LAT(MUL_LAT), .ID_W(ID_W), .RES_W(RES_W)) u_mul (
    .clk(clk), .rst_b(rst_b),
    .start(mul_start), .start_id(head.id), .start_data(mul_data), .start_err(1'b0),
    .accept(mul_accept),
    .idle(mul_idle), .done(mul_done),
    .res_id(mul_res_id), .res_data(mul_res_data), .res_err(mul_res_err)
  );

  // A stalled response keeps its grant so the other slot finishing cannot swap it out.
  always_comb begin
    if (lock_q)                gnt_mul = lock_mul_q;
    else if (add_done && mul_done) gnt_mul = ptr_mul_q;
    else                       gnt_mul = mul_done;
    rsp_valid  = add_done || mul_done;
    accept     = rsp_valid && rsp_ready;
    add_accept = accept && !gnt_mul;
    mul_accept = accept && gnt_mul;
    ptr_mul_d  = accept ? !gnt_mul : ptr_mul_q;
    lock_d     = rsp_valid && !rsp_ready;
    lock_mul_d = gnt_mul;
  end

  always_comb begin
    rsp_id   = '0;
    rsp_data = '0;
    rsp_err  = 1'b0;
    if (rsp_valid) begin
      rsp_id   = gnt_mul ? mul_res_id   : add_res_id;
      rsp_data = gnt_mul ? mul_res_data : add_res_data;
      rsp_err  = gnt_mul ? mul_res_err  : add_res_err;
    end
    fifo_full  = full;
    fifo_count = count_q;
  end
endmodule

// File: tb/tb_exec_unit_mp.sv
// Testbench for exec_unit_mp: directed vector table, multi-cycle corner sequences and
// randomized traffic compared every cycle against a queue-based reference model.

module tb_exec_unit_mp;
  localparam int DATA_W     = 32;
  localparam int ID_W       = 3;
  localparam int FIFO_DEPTH = 4;
  localparam int ADD_LAT    = 1;
  localparam int MUL_LAT    = 3;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int RES_W      = 2 * DATA_W;

  logic              clk;
  logic              rst_b;
  logic              req_valid;
  logic [1:0]        req_op;
  logic [ID_W-1:0]   req_id;
  logic [DATA_W-1:0] req_data1, req_data2;
  logic              fifo_full;
  logic [CNT_W-1:0]  fifo_count;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [RES_W-1:0]  rsp_data;
  logic              rsp_err;

  int checks = 0;
  int passed = 0;

  exec_unit_mp #(
    .DATA_W(DATA_W), .ID_W(ID_W), .FIFO_DEPTH(FIFO_DEPTH), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_op(req_op), .req_id(req_id),
    .req_data1(req_data1), .req_data2(req_data2),
    .fifo_full(fifo_full), .fifo_count(fifo_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a request queue plus, per unit (0 = add, 1 = mul), the cycle its result appears.
  typedef struct {
    logic [1:0]        op;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } req_t;

  req_t             m_fifo[$];
  bit               m_busy[2];
  longint           m_ready_at[2];
  logic [ID_W-1:0]  m_id[2];
  logic [RES_W-1:0] m_data[2];
  bit               m_err[2];
  int               m_ptr;
  bit               m_locked;
  int               m_held;
  longint           m_cyc = 0;

  int               got_n;
  logic [ID_W-1:0]  got_id[16];
  logic [RES_W-1:0] got_data[16];

  typedef struct {
    logic [1:0]        op;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [RES_W-1:0]  exp_data;
    bit                exp_err;
    int                exp_lat;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [RES_W-1:0] ref_result(logic [1:0] op, logic [DATA_W-1:0] a,
                                                 logic [DATA_W-1:0] b);
    longint unsigned x, y;
    x = a;
    y = b;
    case (op)
      2'b00:   return x + y;
      2'b01:   return (x - y) & 64'h0000_0000_FFFF_FFFF;
      2'b10:   return x * y;
      default: return '0;
    endcase
  endfunction

  function automatic bit model_done(int u);
    return m_busy[u] && (m_cyc >= m_ready_at[u]);
  endfunction

  function automatic int model_grant();
    if (m_locked) return m_held;
    if (model_done(0) && model_done(1)) return m_ptr;
    return model_done(1) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    m_busy[0] = 0;
    m_busy[1] = 0;
    m_ptr     = 0;
    m_locked  = 0;
    m_held    = 0;
  endfunction

  task automatic model_step(input bit v, input req_t r, input bit rdy);
    bit   valid, acc, disp, push;
    int   g, tgt;
    req_t h;
    valid = model_done(0) || model_done(1);
    g     = model_grant();
    acc   = valid && rdy;
    disp  = 0;
    tgt   = 0;
    if (m_fifo.size() > 0) begin
      tgt  = (m_fifo[0].op == 2'b10) ? 1 : 0;
      disp = !m_busy[tgt];
    end
    push = v && (m_fifo.size() < FIFO_DEPTH);
    m_cyc++;
    if (acc) begin
      m_busy[g] = 0;
      m_ptr     = 1 - g;
    end
    m_locked = valid && !rdy;
    m_held   = g;
    if (disp) begin
      h               = m_fifo.pop_front();
      m_busy[tgt]     = 1;
      m_ready_at[tgt] = m_cyc + ((tgt == 1) ? MUL_LAT : ADD_LAT);
      m_id[tgt]       = h.id;
      m_data[tgt]     = ref_result(h.op, h.a, h.b);
      m_err[tgt]      = (h.op == 2'b11);
    end
    if (push) m_fifo.push_back(r);
  endtask

  task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic checkOutput(input string name);
    bit               v;
    int               g;
    logic [ID_W-1:0]  eid;
    logic [RES_W-1:0] edata;
    bit               eerr;
    v     = model_done(0) || model_done(1);
    g     = model_grant();
    eid   = '0;
    edata = '0;
    eerr  = 0;
    if (v) begin
      eid   = m_id[g];
      edata = m_data[g];
      eerr  = m_err[g];
    end
    check({name, ".rsp_valid"},  RES_W'(rsp_valid),  RES_W'(v));
    check({name, ".rsp_id"},     RES_W'(rsp_id),     RES_W'(eid));
    check({name, ".rsp_data"},   rsp_data,           edata);
    check({name, ".rsp_err"},    RES_W'(rsp_err),    RES_W'(eerr));
    check({name, ".fifo_count"}, RES_W'(fifo_count), RES_W'(m_fifo.size()));
    check({name, ".fifo_full"},  RES_W'(fifo_full),  RES_W'(m_fifo.size() == FIFO_DEPTH));
  endtask

  task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [ID_W-1:0] id,
                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    req_valid = v;
    req_op    = op;
    req_id    = id;
    req_data1 = a;
    req_data2 = b;
  endtask

  task automatic tick(input string name);
    req_t r;
    bit   v, rdy;
    r.op = req_op;
    r.id = req_id;
    r.a  = req_data1;
    r.b  = req_data2;
    v    = req_valid;
    rdy  = rsp_ready;
    @(posedge clk);
    model_step(v, r, rdy);
    #1;
    checkOutput(name);
  endtask

  task automatic do_reset();
    rst_b = 1'b1;
    applyStimulus(1'b0, 2'b00, '0, '0, '0);
    model_reset();
    #1;
    check("reset_ctrl", RES_W'({rsp_valid, rsp_id, rsp_err, fifo_full, fifo_count}), '0);
    check("reset_data", rsp_data, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b0;
  endtask

  // Every sample with rsp_valid is a distinct response because rsp_ready stays high.
  task automatic collect(input int budget);
    got_n = 0;
    for (int i = 0; i < budget; i++) begin
      if (rsp_valid && got_n < 16) begin
        got_id[got_n]   = rsp_id;
        got_data[got_n] = rsp_data;
        got_n++;
      end
      tick("collect");
    end
  endtask

  initial begin
    int              n;
    logic [ID_W-1:0] bp_ids[4];
    logic [RES_W-1:0] bp_data[4];

    bp_ids  = '{3'd2, 3'd1, 3'd3, 3'd4};
    bp_data = '{64'd30, 64'd42, 64'd70, 64'd110};

    vecs[0] = '{2'b00, 3'd5, 32'hFFFF_FFFF, 32'h1,         64'h0000_0001_0000_0000, 1'b0, ADD_LAT + 1};
    vecs[1] = '{2'b01, 3'd0, 32'd3,         32'd5,         64'h0000_0000_FFFF_FFFE, 1'b0, ADD_LAT + 1};
    vecs[2] = '{2'b10, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, MUL_LAT + 1};
    vecs[3] = '{2'b11, 3'd7, 32'd9,         32'd9,         64'h0,                   1'b1, ADD_LAT + 1};
    vecs[4] = '{2'b01, 3'd1, 32'd5,         32'd3,         64'h2,                   1'b0, ADD_LAT + 1};
    vecs[5] = '{2'b10, 3'd3, 32'h1234_5678, 32'h10,        64'h0000_0001_2345_6780, 1'b0, MUL_LAT + 1};
    vecs[6] = '{2'b00, 3'd4, 32'h8000_0000, 32'h8000_0000, 64'h0000_0001_0000_0000, 1'b0, ADD_LAT + 1};
    vecs[7] = '{2'b01, 3'd6, 32'd0,         32'd0,         64'h0,                   1'b0, ADD_LAT + 1};

    rst_b     = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 2'b00, '0, '0, '0);
    @(posedge clk);
    #1;
    do_reset();

    // Directed vectors: one request at a time into an idle unit, checking latency and result.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].id, vecs[i].a, vecs[i].b);
      rsp_ready = 1'b1;
      tick("vec");
      applyStimulus(1'b0, 2'b00, '0, '0, '0);
      n = 0;
      while (!rsp_valid && n < 20) begin
        tick("vec");
        n++;
      end
      check($sformatf("vec%0d_latency", i), RES_W'(n), RES_W'(vecs[i].exp_lat));
      check($sformatf("vec%0d_id", i), RES_W'(rsp_id), RES_W'(vecs[i].id));
      check($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp_data);
      check($sformatf("vec%0d_err", i), RES_W'(rsp_err), RES_W'(vecs[i].exp_err));
      tick("vec");
      tick("vec");
    end

    // Backpressure: add(2) finishes first and must hold while the FIFO stalls behind it.
    do_reset();
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 2'b10, 3'd1, 32'd6, 32'd7);   tick("bp");
    applyStimulus(1'b1, 2'b00, 3'd2, 32'd10, 32'd20); tick("bp");
    applyStimulus(1'b1, 2'b00, 3'd3, 32'd30, 32'd40); tick("bp");
    applyStimulus(1'b1, 2'b00, 3'd4, 32'd50, 32'd60); tick("bp");
    applyStimulus(1'b0, 2'b00, '0, '0, '0);
    for (int i = 0; i < 10; i++) begin
      tick("bp");
      check("bp_hold_valid", RES_W'(rsp_valid), RES_W'(1));
      check("bp_hold_id", RES_W'(rsp_id), RES_W'(2));
      check("bp_hold_count", RES_W'(fifo_count), RES_W'(2));
    end
    rsp_ready = 1'b1;
    collect(30);
    check("bp_resp_count", RES_W'(got_n), RES_W'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_order%0d_id", i), RES_W'(got_id[i]), RES_W'(bp_ids[i]));
      check($sformatf("bp_order%0d_data", i), got_data[i], bp_data[i]);
    end

    // Full FIFO: seven pushes with the consumer stalled; the last two are dropped.
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 3; i++) begin
      applyStimulus(1'b1, 2'b00, ID_W'(i), DATA_W'(i), 32'd100);
      tick("full");
    end
    applyStimulus(1'b0, 2'b00, '0, '0, '0);
    check("full_flag", RES_W'(fifo_full), RES_W'(1));
    check("full_count", RES_W'(fifo_count), RES_W'(FIFO_DEPTH));
    tick("full");
    rsp_ready = 1'b1;
    collect(40);
    check("full_resp_count", RES_W'(got_n), RES_W'(5));
    for (int i = 0; i < 5; i++) begin
      check($sformatf("full_resp%0d_id", i), RES_W'(got_id[i]), RES_W'(i));
      check($sformatf("full_resp%0d_data", i), got_data[i], RES_W'(i + 100));
    end

    // Reset while the multiplier runs and two more requests wait in the FIFO.
    do_reset();
    rsp_ready = 1'b1;
    applyStimulus(1'b1, 2'b10, 3'd1, 32'd3, 32'd4); tick("rst");
    applyStimulus(1'b1, 2'b10, 3'd2, 32'd5, 32'd6); tick("rst");
    applyStimulus(1'b1, 2'b10, 3'd3, 32'd7, 32'd8); tick("rst");
    check("rst_pre_count", RES_W'(fifo_count), RES_W'(2));
    do_reset();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick("rst_after");
      if (rsp_valid) n++;
    end
    check("rst_no_response", RES_W'(n), RES_W'(0));

    // Randomized traffic with random backpressure against the reference model.
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)), ID_W'($urandom),
                    $urandom,
                    ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 7)) : DATA_W'($urandom));
      rsp_ready = ($urandom_range(0, 9) < 7);
      tick("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
